fifo_cascade_rr_arbiter: RTL
============================

Name: fifo_cascade_rr_arbiter

Overview:
- Round-robin arbiter that shares one AXI-side FIFO cascade input among NUM_SRC AXI-stream requesters.
- Grants one source at a time for a burst of up to BURST beats.
- Admits a burst only when the cascade reports space >= BURST, so a granted burst never stalls on a full cascade.
- Sits between user-processing-core stream producers and the cascade's tdata_i/tvalid_i/tready_i/space.

Parameters:
- WIDTH, 32, data width per source and on the output.
- NUM_SRC, 4, number of requesters (2..8).
- BURST, 16, maximum beats per grant (1..256).

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- clear  in  1  synchronous soft clear; same effect as reset, active high.
- s_tdata  in  WIDTH*NUM_SRC  source data, source k at bits [k*WIDTH +: WIDTH].
- s_tvalid  in  NUM_SRC  source valid, one bit per source.
- s_tready  out  NUM_SRC  source ready, one-hot or zero.
- o_tdata  out  WIDTH  to cascade tdata_i.
- o_tvalid  out  1  to cascade tvalid_i.
- o_tready  in  1  from cascade tready_i.
- space  in  16  cascade free-entry count.
- grant  out  NUM_SRC  current one-hot grant, zero when idle.
- busy  out  1  high in GRANT state.

Behaviour:
- States:
  - IDLE: default state.
  - GRANT: a source holds the cascade input.
- Reset or clear:
  - state=IDLE, grant=0, busy=0, beat counter=0.
  - rr pointer = NUM_SRC-1, so source 0 has first priority.
  - s_tready=0, o_tvalid=0.
  - Reset and clear take effect mid-burst too; the partial burst is abandoned with no further handshakes.
- IDLE to GRANT:
  - Condition: any s_tvalid=1 and space >= BURST (unsigned 16-bit compare).
  - Winner is the first requester strictly after the rr pointer, searching cyclically.
  - grant is registered; the winner sees s_tready starting the next cycle (1-cycle arbitration latency).
  - rr pointer <= winner index.
- GRANT datapath:
  - o_tdata = s_tdata[g], o_tvalid = s_tvalid[g], s_tready[g] = o_tready; all combinational.
  - All other s_tready bits are 0.
  - A beat is counted when s_tvalid[g] & o_tready.
- GRANT to IDLE:
  - The cycle the counted beat brings the counter to BURST.
  - Or any GRANT cycle with s_tvalid[g]=0 (source idle; gives up the grant). This includes the first GRANT cycle.
  - The counter clears on exit.
- Minimum gap between bursts is one IDLE cycle. There is no back-to-back grant.
- o_tready low in GRANT: hold the state, no count. Not expected given the admission check, but must be tolerated.
- space is sampled only in IDLE. A space change during GRANT has no effect.
- BURST=1: each grant transfers exactly one beat, then returns to IDLE.
- Beat counter width: clog2(BURST+1).
- Fairness: a source that just finished cannot win again while any other source requests.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - Adds output beat_count, width 32*NUM_SRC: per-source count of accepted beats, wrapping at 2^32.
  - Adds output burst_abort, width 16: count of grants ended early by source-idle, saturating at 16'hFFFF.
  - Both cleared by reset or clear.
- Undefined: neither port nor any counter logic exists.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1;
  - the clog2 function;
  - the default BURST constant.
- One sub-module, rr_pick:
  - purely combinational;
  - inputs: req[NUM_SRC], ptr;
  - outputs: one-hot win and win_idx.
  - Reused by other arbiters in the core.

Test Plan:
- Reset/IDLE: resetn=0 for 2 cycles, all s_tvalid=1, space=100 -> grant=0, s_tready=0, o_tvalid=0. First grant=4'b0001 two cycles after release.
- Full bursts: NUM_SRC=4, BURST=16, sources 0 and 2 always valid, o_tready=1, space=100 -> grants alternate 0001, 0100, 0001. Each burst is exactly 16 beats, data is in order, with one idle cycle between bursts.
- Admission: space=15, s_tvalid=0001 -> no grant for 50 cycles. Space changes to 16 -> grant=0001 next cycle.
- Early release: source 1 drops tvalid after 5 beats -> return to IDLE that cycle with 5 beats accepted. With FIFO_ARB_STATS_EN: burst_abort=1, beat_count[1]=5.
- Mid-burst clear: clear=1 at beat 8 of source 3 -> next cycle grant=0, s_tready=0. Afterwards source 0 wins over source 3 when both request.
- Backpressure: o_tready toggled 1,0,1,0 during a grant -> only the 1-cycles are counted. The burst ends after exactly 16 accepted beats with no duplicated or lost data.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the cascade-input arbiters.
// Holds the arbiter state encoding, the default burst length and a
// clog2 helper used to size indices and beat counters.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int DEFAULT_BURST = 16;

    // Ceiling log2, never smaller than 1 so that a result can always be
    // used directly as a vector width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_cascade_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker shared by the core's arbiters.
// Finds the first requester strictly after ptr, searching cyclically, so
// the previous winner (ptr) has the lowest priority.
// Ports:
//   req     in  NUM_SRC  request vector
//   ptr     in  IDX_W    index of the last winner
//   win     out NUM_SRC  one-hot winner, zero when nothing requests
//   win_idx out IDX_W    winner index, zero when nothing requests
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] win,
    output logic [IDX_W-1:0]   win_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk the candidates ptr+1, ptr+2, ... wrapping at NUM_SRC; the first
    // requesting candidate wins and later ones are ignored.
    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int off = 1; off <= NUM_SRC; off++) begin
            cand = IDX_W'((int'(ptr) + off) % NUM_SRC);
            if (!found && req[cand]) begin
                found     = 1'b1;
                win[cand] = 1'b1;
                win_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_cascade_rr_arbiter.sv
// fifo_cascade_rr_arbiter: shares one FIFO-cascade input among NUM_SRC
// AXI-stream producers. One source at a time is granted for up to BURST
// beats, and a grant is only issued while the cascade reports at least
// BURST free entries, so a granted burst never meets a full cascade.
// Optional statistics are built when FIFO_ARB_STATS_EN is defined.
// Ports:
//   clk, resetn   clock and synchronous active-low reset
//   clear         synchronous soft clear, same effect as reset
//   s_tdata/s_tvalid/s_tready   per-source stream inputs (source k at k*WIDTH)
//   o_tdata/o_tvalid/o_tready   stream towards the cascade input
//   space         cascade free-entry count, sampled only while idle
//   grant         one-hot current grant, zero when idle
//   busy          high while a source holds the grant
//   beat_count    (FIFO_ARB_STATS_EN) per-source accepted beats, 32 bits each
//   burst_abort   (FIFO_ARB_STATS_EN) grants ended by an idle source, saturating
module fifo_cascade_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int BURST   = DEFAULT_BURST
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic [WIDTH*NUM_SRC-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]       s_tvalid,
    output logic [NUM_SRC-1:0]       s_tready,
    output logic [WIDTH-1:0]         o_tdata,
    output logic                     o_tvalid,
    input  logic                     o_tready,
    input  logic [15:0]              space,
    output logic [NUM_SRC-1:0]       grant,
`ifdef FIFO_ARB_STATS_EN
    output logic                     busy,
    output logic [32*NUM_SRC-1:0]    beat_count,
    output logic [15:0]              burst_abort
`else
    output logic                     busy
`endif
);

    localparam int               IDX_W       = clog2(NUM_SRC);
    localparam int               CNT_W       = clog2(BURST + 1);
    localparam logic [15:0]      BURST_SPACE = 16'(BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BURST - 1);
    localparam logic [IDX_W-1:0] PTR_INIT    = IDX_W'(NUM_SRC - 1);

    state_t             state;
    state_t             next_state;
    logic [NUM_SRC-1:0] grant_q;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_SRC-1:0] win;
    logic [IDX_W-1:0]   win_idx;
    logic [CNT_W-1:0]   beat_cnt;
    logic               src_valid;
    logic               beat;
    logic               start_grant;
    logic               end_grant;
    logic               soft_reset;

    rr_pick #(
        .NUM_SRC(NUM_SRC),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .req    (s_tvalid),
        .ptr    (rr_ptr),
        .win    (win),
        .win_idx(win_idx)
    );

    assign soft_reset  = !resetn || clear;
    assign src_valid   = s_tvalid[grant_idx];
    assign beat        = (state == ST_GRANT) && src_valid && o_tready;
    assign start_grant = (state == ST_IDLE)  && (next_state == ST_GRANT);
    assign end_grant   = (state == ST_GRANT) && (next_state == ST_IDLE);
    assign grant       = grant_q;

    // State register; clear behaves exactly like reset and may cut a burst short.
    always_ff @(posedge clk) begin
        if (soft_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Admission is decided only from IDLE, so a change of space during a
    // burst is ignored. A grant ends on its last counted beat or as soon as
    // the granted source stops presenting data.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if ((|s_tvalid) && (space >= BURST_SPACE)) begin
                    next_state = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!src_valid || (beat && (beat_cnt == LAST_BEAT))) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Grant bookkeeping. The pointer starts at NUM_SRC-1 so source 0 has
    // first priority, and it moves to each new winner so that winner drops
    // to lowest priority for the following arbitration.
    always_ff @(posedge clk) begin
        if (soft_reset) begin
            grant_q   <= '0;
            grant_idx <= '0;
            rr_ptr    <= PTR_INIT;
            beat_cnt  <= '0;
        end else if (start_grant) begin
            grant_q   <= win;
            grant_idx <= win_idx;
            rr_ptr    <= win_idx;
            beat_cnt  <= '0;
        end else if (end_grant) begin
            grant_q   <= '0;
            beat_cnt  <= '0;
        end else if (beat) begin
            beat_cnt  <= beat_cnt + CNT_W'(1);
        end
    end

    // The granted source is wired straight through to the cascade; every
    // other source sees s_tready low.
    always_comb begin
        busy     = (state == ST_GRANT);
        o_tvalid = 1'b0;
        o_tdata  = '0;
        s_tready = '0;
        if (state == ST_GRANT) begin
            o_tvalid            = src_valid;
            o_tdata             = s_tdata[grant_idx*WIDTH +: WIDTH];
            s_tready[grant_idx] = o_tready;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Accepted beats per source wrap naturally; early-release count sticks
    // at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (soft_reset) begin
            beat_count  <= '0;
            burst_abort <= '0;
        end else begin
            if (beat) begin
                beat_count[grant_idx*32 +: 32] <= beat_count[grant_idx*32 +: 32] + 32'd1;
            end
            if ((state == ST_GRANT) && !src_valid && (burst_abort != 16'hFFFF)) begin
                burst_abort <= burst_abort + 16'd1;
            end
        end
    end
`endif

endmodule
